dma_desc_sequencer: RTL and testbench
=====================================

# dma_desc_sequencer

Upstream feeder for the DMA AXI wrapper: accepts transfer commands on a valid/ready stream from the accelerator controller, packs them into the DMA's descriptor slots, launches the DMA with `go`, and tracks completion, error and abort. It replaces the CSR path with a hardware command queue, and its descriptor and control outputs connect 1:1 to the DMA descriptor vectors and control fields.

## Interface
- `NUM_DESC`, 2: descriptor slots; must equal the DMA's descriptor count.
- `ADDR_W`, 32: width of the address and byte-count fields.
- `TIMEOUT_CYCLES`, 65535: watchdog limit. Used only with `DMA_SEQ_TIMEOUT_EN`.

Ports:
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-low reset.
- `cmd_valid_i` in 1: command valid.
- `cmd_ready_o` out 1: command ready.
- `cmd_src_i` in ADDR_W: source address.
- `cmd_dst_i` in ADDR_W: destination address.
- `cmd_bytes_i` in ADDR_W: byte count.
- `cmd_rd_mode_i` in 1: read mode (0 incr, 1 fixed).
- `cmd_wr_mode_i` in 1: write mode (0 incr, 1 fixed).
- `cmd_last_i` in 1: closes the batch.
- `dma_desc_src_vec_o` out NUM_DESC*ADDR_W: slot i occupies bits [i*ADDR_W +: ADDR_W].
- `dma_desc_dst_vec_o` out NUM_DESC*ADDR_W: same packing.
- `dma_desc_byt_vec_o` out NUM_DESC*ADDR_W: same packing.
- `dma_desc_rd_mod_o` out NUM_DESC: per-slot read mode.
- `dma_desc_wr_mod_o` out NUM_DESC: per-slot write mode.
- `dma_desc_en_o` out NUM_DESC: per-slot enable.
- `dma_go_o` out 1: DMA go.
- `dma_abort_o` out 1: DMA abort request.
- `dma_done_i` in 1: DMA done.
- `dma_error_i` in 1: DMA error.
- `busy_o` out 1: a batch is loaded or running.
- `batch_done_o` out 1: one-cycle pulse at batch end.
- `batch_err_o` out 1: sticky error flag.

## Operation
**States:** IDLE, FILL, RUN, ABORT, DRAIN.

**Reset:** all outputs 0, slot count 0, state IDLE.

**IDLE / FILL (loading):**
- `cmd_ready_o` = 1 while slot count < NUM_DESC.
- On each handshake, the command is written to slot [count], that slot's enable is set, and count increments.
- The first handshake in IDLE moves to FILL and clears `batch_err_o`.

**Zero-byte commands:**
- Accepted but not stored.
- `cmd_last_i` on a zero-byte command still closes the batch.

**Batch close:**
- A batch closes on `cmd_last_i` at handshake, or when count reaches NUM_DESC.
- With count > 0, go to RUN.
- With count = 0, pulse `batch_done_o` and return to IDLE; `dma_go_o` is not asserted.

**RUN:**
- `dma_go_o` = 1 and `cmd_ready_o` = 0.
- `dma_done_i` = 1 with `dma_error_i` = 0: drop go, pulse `batch_done_o`, go to DRAIN.
- `dma_error_i` = 1 (takes priority over done in the same cycle): set `batch_err_o`, go to ABORT.

**ABORT:**
- `dma_abort_o` = 1 and `dma_go_o` = 0.
- Hold until `dma_done_i` = 1, then pulse `batch_done_o` and go to DRAIN.

**DRAIN:**
- Outputs held deasserted: `dma_go_o` = 0, `dma_abort_o` = 0.
- On `dma_done_i` = 0: clear all slot enables and the count, go to IDLE.
- This keeps stale `done` from retriggering the next batch.

**Other rules:**
- `busy_o` = 1 in FILL, RUN, ABORT and DRAIN.
- Descriptor fields of disabled slots hold their last value; only the enables are cleared.

## Timing
- All outputs are registered.
- A command accepted at edge N is visible on the descriptor vectors after edge N.
- `dma_go_o` rises one cycle after the closing handshake.
- `batch_done_o` is asserted for exactly one cycle, in the cycle after `dma_done_i` is sampled high.
- Minimum batch turnaround is 4 cycles: close → RUN → done → DRAIN → IDLE.
- Asserting `rst` in any state asynchronously returns the block to IDLE with all outputs 0, including mid-RUN. A DMA that is still running is not aborted by this block.

## Configuration
**`DMA_SEQ_TIMEOUT_EN`:**
- Defined: a cycle counter runs in RUN and saturates at TIMEOUT_CYCLES.
- Reaching TIMEOUT_CYCLES without `dma_done_i` sets `batch_err_o` and enters ABORT.
- The counter clears on entry to RUN.
- Undefined: no counter, and RUN waits indefinitely.

## Test plan
1. **Two-command batch.** Commands src 0x1000/dst 0x2000/64 B, then src 0x1100/dst 0x2100/32 B with last; DMA done after 20 cycles → `dma_desc_en_o` = 2'b11 and go high from 1 cycle after the second handshake; `batch_done_o` pulses once; state returns to IDLE after done falls.
2. **Auto-close on full slots.** NUM_DESC = 2, two commands without `last` → RUN entered; `cmd_ready_o` = 0 until DRAIN completes.
3. **Zero-byte command.** Single 0-byte command with last → `batch_done_o` pulses; `dma_go_o` never rises.
4. **DMA error.** `dma_error_i` and `dma_done_i` high in the same RUN cycle → ABORT with `dma_abort_o` = 1 and `batch_err_o` = 1. `batch_err_o` stays set until the next batch's first accept.
5. **Reset mid-RUN.** Drive `rst` low mid-RUN → all outputs 0 immediately; after release, a new batch loads from slot 0.
6. **Watchdog (`DMA_SEQ_TIMEOUT_EN`, TIMEOUT_CYCLES = 100).** Withhold done → ABORT entered at cycle 100 of RUN with `batch_err_o` = 1.

Source files
------------

// File: rtl/dma_desc_sequencer.sv
// Hardware command queue feeding the DMA descriptor slots: loads a batch, fires go, waits out done/error.
// Optional watchdog on the RUN state is enabled by defining DMA_SEQ_TIMEOUT_EN.
module dma_desc_sequencer #(
  parameter int NUM_DESC       = 2,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic [ADDR_W-1:0]          cmd_src_i,
  input  logic [ADDR_W-1:0]          cmd_dst_i,
  input  logic [ADDR_W-1:0]          cmd_bytes_i,
  input  logic                       cmd_rd_mode_i,
  input  logic                       cmd_wr_mode_i,
  input  logic                       cmd_last_i,
  output logic [NUM_DESC*ADDR_W-1:0] dma_desc_src_vec_o,
  output logic [NUM_DESC*ADDR_W-1:0] dma_desc_dst_vec_o,
  output logic [NUM_DESC*ADDR_W-1:0] dma_desc_byt_vec_o,
  output logic [NUM_DESC-1:0]        dma_desc_rd_mod_o,
  output logic [NUM_DESC-1:0]        dma_desc_wr_mod_o,
  output logic [NUM_DESC-1:0]        dma_desc_en_o,
  output logic                       dma_go_o,
  output logic                       dma_abort_o,
  input  logic                       dma_done_i,
  input  logic                       dma_error_i,
  output logic                       busy_o,
  output logic                       batch_done_o,
  output logic                       batch_err_o
);
  localparam int CW = $clog2(NUM_DESC + 1);

  if (NUM_DESC < 1 || ADDR_W < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("dma_desc_sequencer: illegal parameter set");
  end

  typedef enum logic [2:0] {IDLE, FILL, RUN, ABORT, DRAIN} state_e;

  state_e                          state_q, state_d;
  logic [CW-1:0]                   cnt_q, cnt_d;
  logic [NUM_DESC-1:0][ADDR_W-1:0] src_q, src_d, dst_q, dst_d, byt_q, byt_d;
  logic [NUM_DESC-1:0]             rdm_q, rdm_d, wrm_q, wrm_d, en_q, en_d;
  logic ready_q, ready_d, go_q, go_d, abort_q, abort_d;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic hs, tmo_hit;

  assign hs = cmd_valid_i & ready_q;

`ifdef DMA_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  // tmo_q counts completed RUN cycles; the hit fires on the edge that completes cycle TIMEOUT_CYCLES
  assign tmo_hit = (state_q == RUN) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    dst_d   = dst_q;
    byt_d   = byt_q;
    rdm_d   = rdm_q;
    wrm_d   = wrm_q;
    en_d    = en_q;
    err_d   = err_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE, FILL: begin
        if (hs) begin
          if (state_q == IDLE) err_d = 1'b0;
          state_d = FILL;
          // zero-byte commands consume a handshake but never a slot
          if (cmd_bytes_i != '0) begin
            for (int i = 0; i < NUM_DESC; i++) begin
              if (cnt_q == CW'(i)) begin
                src_d[i] = cmd_src_i;
                dst_d[i] = cmd_dst_i;
                byt_d[i] = cmd_bytes_i;
                rdm_d[i] = cmd_rd_mode_i;
                wrm_d[i] = cmd_wr_mode_i;
                en_d[i]  = 1'b1;
              end
            end
            cnt_d = cnt_q + 1'b1;
          end
          if (cmd_last_i || cnt_d == CW'(NUM_DESC)) begin
            if (cnt_d != '0) begin
              state_d = RUN;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end
      RUN: begin
        if (dma_error_i) begin
          err_d   = 1'b1;
          state_d = ABORT;
        end else if (dma_done_i) begin
          done_d  = 1'b1;
          state_d = DRAIN;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = ABORT;
        end
      end
      ABORT: begin
        if (dma_done_i) begin
          done_d  = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // wait for done to fall so a stale level cannot complete the next batch
        if (!dma_done_i) begin
          en_d    = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    go_d    = (state_d == RUN);
    abort_d = (state_d == ABORT);
    busy_d  = (state_d != IDLE);
    ready_d = ((state_d == IDLE) || (state_d == FILL)) && (cnt_d < CW'(NUM_DESC));
`ifdef DMA_SEQ_TIMEOUT_EN
    tmo_d = tmo_q;
    if (state_d == RUN) begin
      if (state_q != RUN)                      tmo_d = '0;
      else if (tmo_q != TW'(TIMEOUT_CYCLES))   tmo_d = tmo_q + 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      byt_q   <= '0;
      rdm_q   <= '0;
      wrm_q   <= '0;
      en_q    <= '0;
      ready_q <= 1'b0;
      go_q    <= 1'b0;
      abort_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef DMA_SEQ_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      byt_q   <= byt_d;
      rdm_q   <= rdm_d;
      wrm_q   <= wrm_d;
      en_q    <= en_d;
      ready_q <= ready_d;
      go_q    <= go_d;
      abort_q <= abort_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef DMA_SEQ_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign cmd_ready_o        = ready_q;
  assign dma_desc_src_vec_o = src_q;
  assign dma_desc_dst_vec_o = dst_q;
  assign dma_desc_byt_vec_o = byt_q;
  assign dma_desc_rd_mod_o  = rdm_q;
  assign dma_desc_wr_mod_o  = wrm_q;
  assign dma_desc_en_o      = en_q;
  assign dma_go_o           = go_q;
  assign dma_abort_o        = abort_q;
  assign busy_o             = busy_q;
  assign batch_done_o       = done_q;
  assign batch_err_o        = err_q;

endmodule

// File: tb/tb_dma_desc_sequencer.sv
// Scoreboard bench for dma_desc_sequencer: expected descriptor sets and batch_done events are queued
// as commands are driven and compared when go rises / batch_done pulses.
module tb_dma_desc_sequencer;
  localparam int ND = 2;
  localparam int AW = 32;
`ifdef DMA_SEQ_TIMEOUT_EN
  localparam int TMO = 100;
`else
  localparam int TMO = 65535;
`endif

  logic clk = 1'b0, rst = 1'b0;
  logic cmd_valid_i = 1'b0, cmd_ready_o;
  logic [AW-1:0] cmd_src_i = '0, cmd_dst_i = '0, cmd_bytes_i = '0;
  logic cmd_rd_mode_i = 1'b0, cmd_wr_mode_i = 1'b0, cmd_last_i = 1'b0;
  logic [ND*AW-1:0] src_vec, dst_vec, byt_vec;
  logic [ND-1:0] rd_mod, wr_mod, en;
  logic dma_go_o, dma_abort_o, dma_done_i = 1'b0, dma_error_i = 1'b0;
  logic busy_o, batch_done_o, batch_err_o;

  dma_desc_sequencer #(.NUM_DESC(ND), .ADDR_W(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_src_i(cmd_src_i), .cmd_dst_i(cmd_dst_i), .cmd_bytes_i(cmd_bytes_i),
    .cmd_rd_mode_i(cmd_rd_mode_i), .cmd_wr_mode_i(cmd_wr_mode_i), .cmd_last_i(cmd_last_i),
    .dma_desc_src_vec_o(src_vec), .dma_desc_dst_vec_o(dst_vec), .dma_desc_byt_vec_o(byt_vec),
    .dma_desc_rd_mod_o(rd_mod), .dma_desc_wr_mod_o(wr_mod), .dma_desc_en_o(en),
    .dma_go_o(dma_go_o), .dma_abort_o(dma_abort_o),
    .dma_done_i(dma_done_i), .dma_error_i(dma_error_i),
    .busy_o(busy_o), .batch_done_o(batch_done_o), .batch_err_o(batch_err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ND*AW-1:0] src, dst, byt;
    logic [ND-1:0]    rdm, wrm, en;
  } desc_t;

  desc_t exp_q[$];
  logic  done_exp_q[$];
  desc_t mdl = '0;
  int    mdl_cnt = 0;
  int    errs = 0, checks = 0, done_cnt = 0, done_total = 0;
  logic  go_prev = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // one clock; sample registered outputs 1ns after the edge and run the scoreboard
  task automatic tick();
    desc_t e;
    @(posedge clk);
    #1;
    if (dma_go_o && !go_prev) begin
      if (exp_q.size() == 0) chk("go_unexpected", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("desc_src", src_vec, e.src);
        chk("desc_dst", dst_vec, e.dst);
        chk("desc_byt", byt_vec, e.byt);
        chk("desc_rdm", rd_mod, e.rdm);
        chk("desc_wrm", wr_mod, e.wrm);
        chk("desc_en", en, e.en);
      end
    end
    if (batch_done_o) begin
      done_cnt++;
      if (done_exp_q.size() == 0) chk("done_unexpected", 1, 0);
      else chk("done_err_flag", batch_err_o, done_exp_q.pop_front());
    end
    go_prev = dma_go_o;
  endtask

  task automatic send(input logic [31:0] s, input logic [31:0] d, input logic [31:0] b,
                      input logic rm, input logic wm, input logic last);
    int n = 0;
    cmd_valid_i = 1'b1; cmd_src_i = s; cmd_dst_i = d; cmd_bytes_i = b;
    cmd_rd_mode_i = rm; cmd_wr_mode_i = wm; cmd_last_i = last;
    while (!cmd_ready_o && n < 50) begin tick(); n++; end
    if (!cmd_ready_o) chk("ready_timeout", 0, 1);
    else begin
      if (b != 0) begin
        mdl.src[mdl_cnt*AW +: AW] = s;
        mdl.dst[mdl_cnt*AW +: AW] = d;
        mdl.byt[mdl_cnt*AW +: AW] = b;
        mdl.rdm[mdl_cnt] = rm;
        mdl.wrm[mdl_cnt] = wm;
        mdl.en[mdl_cnt]  = 1'b1;
        mdl_cnt++;
      end
      if (last || mdl_cnt == ND) begin
        if (mdl_cnt > 0) exp_q.push_back(mdl);
        else begin done_exp_q.push_back(1'b0); done_total++; end
      end
      tick();
    end
    cmd_valid_i = 1'b0; cmd_last_i = 1'b0;
  endtask

  // hold RUN for some cycles, then complete the DMA normally
  task automatic finish_ok(input int run_cycles);
    int lows = 0;
    for (int i = 0; i < run_cycles; i++) begin
      tick();
      if (!dma_go_o || cmd_ready_o) lows++;
    end
    chk("run_go_held_ready_low", lows, 0);
    dma_done_i = 1'b1;
    done_exp_q.push_back(1'b0); done_total++;
    tick();
    chk("done_go_drop", dma_go_o, 0);
    chk("drain_busy", busy_o, 1);
    tick();
    chk("done_one_cycle", batch_done_o, 0);
    chk("drain_ready_low", cmd_ready_o, 0);
    dma_done_i = 1'b0;
    tick();
    chk("idle_busy", busy_o, 0);
    chk("idle_en_clear", en, 0);
    chk("idle_ready", cmd_ready_o, 1);
    mdl.en = '0; mdl_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // reset state
    tick(); tick();
    chk("rst_ready", cmd_ready_o, 0);
    chk("rst_go", dma_go_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_src", src_vec, 0);
    rst = 1'b1;
    tick();
    chk("post_rst_ready", cmd_ready_o, 1);
    chk("post_rst_busy", busy_o, 0);

    // two-command batch
    send(32'h1000, 32'h2000, 32'd64, 1'b0, 1'b0, 1'b0);
    chk("t1_en_first", en, 2'b01);
    chk("t1_busy", busy_o, 1);
    chk("t1_go_low", dma_go_o, 0);
    chk("t1_slot0_src", src_vec[AW-1:0], 32'h1000);
    send(32'h1100, 32'h2100, 32'd32, 1'b0, 1'b0, 1'b1);
    chk("t1_go_rise", dma_go_o, 1);
    chk("t1_en_both", en, 2'b11);
    finish_ok(20);

    // auto-close on full slots, mixed modes; command held pending while RUN
    send(32'h3000, 32'h4000, 32'd16, 1'b1, 1'b0, 1'b0);
    send(32'h3100, 32'h4100, 32'd8, 1'b0, 1'b1, 1'b0);
    chk("t2_go", dma_go_o, 1);
    finish_ok(5);

    // zero-byte command closing an empty batch
    send(32'hdead, 32'hbeef, 32'd0, 1'b0, 1'b0, 1'b1);
    chk("t3_go_low", dma_go_o, 0);
    chk("t3_busy", busy_o, 0);
    for (int i = 0; i < 3; i++) tick();
    chk("t3_go_never", dma_go_o, 0);
    chk("t3_en", en, 0);

    // zero-byte in the middle of a batch takes no slot
    send(32'h5555, 32'h6666, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("t3b_en_none", en, 0);
    send(32'h3800, 32'h4800, 32'd4, 1'b0, 1'b0, 1'b1);
    chk("t3b_en_one", en, 2'b01);
    finish_ok(2);

    // error and done together in RUN
    send(32'h5000, 32'h6000, 32'd128, 1'b0, 1'b0, 1'b1);
    tick(); tick();
    dma_error_i = 1'b1; dma_done_i = 1'b1;
    tick();
    chk("t4_abort", dma_abort_o, 1);
    chk("t4_go_low", dma_go_o, 0);
    chk("t4_err", batch_err_o, 1);
    chk("t4_no_done_yet", batch_done_o, 0);
    done_exp_q.push_back(1'b1); done_total++;
    tick();
    chk("t4_abort_drop", dma_abort_o, 0);
    dma_error_i = 1'b0; dma_done_i = 1'b0;
    tick();
    chk("t4_idle", busy_o, 0);
    chk("t4_err_sticky", batch_err_o, 1);
    mdl.en = '0; mdl_cnt = 0;

    // next batch's first accept clears the error, then reset mid-RUN
    send(32'h6000, 32'h7000, 32'd12, 1'b1, 1'b1, 1'b1);
    chk("t4_err_cleared", batch_err_o, 0);
    tick(); tick();
    #2 rst = 1'b0;
    #1;
    chk("t5_go", dma_go_o, 0);
    chk("t5_busy", busy_o, 0);
    chk("t5_en", en, 0);
    chk("t5_src", src_vec, 0);
    chk("t5_ready", cmd_ready_o, 0);
    go_prev = 1'b0; mdl = '0; mdl_cnt = 0;
    tick();
    rst = 1'b1;
    tick();
    send(32'h7000, 32'h8000, 32'd20, 1'b0, 1'b0, 1'b1);
    chk("t5_slot0", en, 2'b01);
    finish_ok(3);

`ifdef DMA_SEQ_TIMEOUT_EN
    begin
      int n = 0;
      send(32'h9000, 32'ha000, 32'd40, 1'b0, 1'b0, 1'b1);
      while (!dma_abort_o && n < 300) begin tick(); n++; end
      chk("t6_abort_cycle", n, TMO);
      chk("t6_err", batch_err_o, 1);
      dma_done_i = 1'b1;
      done_exp_q.push_back(1'b1); done_total++;
      tick();
      dma_done_i = 1'b0;
      tick();
      chk("t6_idle", busy_o, 0);
      mdl.en = '0; mdl_cnt = 0;
    end
`endif

    chk("exp_q_empty", exp_q.size(), 0);
    chk("done_q_empty", done_exp_q.size(), 0);
    chk("done_count", done_cnt, done_total);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
